// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between message requesters, the arbiter and UART_TX_CTRL.
// Latency: none (wires only).
// Backpressure: requesters hold req_* until req_ack; ready gates every transmitter load.
//
// Signals:
//   req_valid/req_data/req_last : per-requester byte offer (byte i in bits [8i+7:8i])
//   req_ack                     : one-cycle pulse, byte of requester i consumed
//   send/send_data/ready        : UART_TX_CTRL load handshake
//   grant/busy/timeout_err      : arbitration status
// Modports: master = requesters + transmitter side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 send;
  logic [7:0]           send_data;
  logic                 ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 timeout_err;

  modport master (
    output req_valid, req_data, req_last, ready,
    input  req_ack, send, send_data, grant, busy, timeout_err
  );

  modport slave (
    input  req_valid, req_data, req_last, ready,
    output req_ack, send, send_data, grant, busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART_TX_CTRL among NUM_REQ sources.
// Latency: valid seen in IDLE with ready=1 -> send and req_ack high the next cycle.
// Backpressure: no load while ready=0; owner keeps the grant until its last byte is sent.
//
// Ports: CLK, RST (async, active-high); bus (uart_tx_arbiter_if.slave) carries the
// requester offers/acks, the transmitter send/send_data/ready handshake and the
// grant/busy/timeout_err status. All outputs are registered.
// Optional: define UART_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT_CYC idle
// cycles mid-message (timeout_err pulses); otherwise timeout_err is tied 0.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic             CLK,
  input logic             RST,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT_RDY, NEXT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               send_q, send_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q;

  // control decisions shared by the next-state and output processes
  logic               load;
  logic [IDX_W-1:0]   load_idx;
  logic               release_grant;
  logic               tmo_hit;

  // round-robin search upward from ptr+1
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_vld && bus.req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_q;

  // counts only while the owner is silent in NEXT; any other state holds it at 0
  assign tmo_hit = (state_q == NEXT) && !bus.req_valid[owner_q] &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (state_q == NEXT && !bus.req_valid[owner_q] && !tmo_hit)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
    end
  end

  assign bus.timeout_err = tmo_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // state register plus registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      owner_q <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      send_q  <= send_d;
      data_q  <= data_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // next-state logic
  always_comb begin
    state_d       = state_q;
    load          = 1'b0;
    load_idx      = owner_q;
    release_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ready && win_vld) begin
          load     = 1'b1;
          load_idx = win_idx;
          state_d  = SETTLE;
        end
      end
      // transmitter needs a cycle to drop ready after send
      SETTLE: state_d = WAIT_RDY;
      WAIT_RDY: begin
        if (bus.ready) begin
          if (last_q) begin
            release_grant = 1'b1;
            state_d       = IDLE;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        // owner only; ready is rechecked so send never fires into a busy transmitter
        if (bus.ready && bus.req_valid[owner_q]) begin
          load    = 1'b1;
          state_d = SETTLE;
        end else if (tmo_hit) begin
          release_grant = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // output / datapath next values
  always_comb begin
    send_d  = load;
    ack_d   = load ? (NUM_REQ'(1) << load_idx) : '0;
    data_d  = load ? bus.req_data[8*load_idx +: 8] : data_q;
    last_d  = load ? bus.req_last[load_idx] : last_q;
    owner_d = load ? load_idx : owner_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (load) begin
      grant_d = NUM_REQ'(1) << load_idx;
    end else if (release_grant) begin
      grant_d = '0;
      ptr_d   = owner_q;
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.send      = send_q;
  assign bus.send_data = data_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requester models, UART_TX_CTRL ready model,
// scoreboard of expected (requester, byte) loads in service order.
// Optional timeout scenario depends on UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;
  localparam int N = 3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- requester models ----------------
  logic [8:0] mbuf [N][32];
  int         hd [N];
  int         tl [N];

  task automatic enq(input int r, input logic [7:0] d, input logic last);
    mbuf[r][tl[r]] = {last, d};
    tl[r]++;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        if (bus.req_ack[i] && hd[i] < tl[i]) hd[i]++;
        if (hd[i] < tl[i]) begin
          bus.req_valid[i]      = 1'b1;
          bus.req_data[8*i +: 8] = mbuf[i][hd[i]][7:0];
          bus.req_last[i]       = mbuf[i][hd[i]][8];
        end else begin
          bus.req_valid[i]      = 1'b0;
          bus.req_data[8*i +: 8] = 8'h00;
          bus.req_last[i]       = 1'b0;
        end
      end
    end
  end

  // ---------------- transmitter ready model ----------------
  int   tx_cnt   = 0;
  int   char_cyc = 20;
  logic hold_rdy = 1'b0;
  assign bus.ready = !hold_rdy && (tx_cnt == 0);

  initial begin
    forever begin
      @(negedge CLK);
      if (bus.send === 1'b1) tx_cnt = char_cyc;
      else if (tx_cnt > 0) tx_cnt--;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0] who;
    logic [7:0] dat;
  } exp_t;
  exp_t sbq[$];
  int n_send = 0;
  int n_ack  = 0;

  task automatic push(input int r, input logic [7:0] d);
    sbq.push_back({2'(r), d});
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (bus.req_ack != '0) n_ack++;
        if (bus.send) begin
          n_send++;
          check("sb_pending", sbq.size() != 0, 1'b1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("send_data", bus.send_data, e.dat);
            check("grant_at_send", bus.grant, 32'(1) << e.who);
            check("ack_at_send", bus.req_ack, 32'(1) << e.who);
          end
        end else if (bus.req_ack != '0) begin
          check("ack_without_send", bus.req_ack, 0);
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (sbq.size() == 0 && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    check(name, done, 1'b1);
  endtask

  task automatic wait_sends(input string name, input int target, input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (n_send >= target) break;
    end
    check(name, n_send >= target, 1'b1);
  endtask

  // ---------------- arbitration vectors ----------------
  typedef struct {
    logic [2:0] mask;   // requesters offering a 1-byte message together
    logic [5:0] ord;    // expected service order, first winner in [1:0]
    int         n;
  } vec_t;
  vec_t vt[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base_s, base_a, bad, pulses, at_c;
    logic [N-1:0] g_at;
    bit   done;

    vt[0] = '{3'b111, {2'd2, 2'd1, 2'd0}, 3};
    vt[1] = '{3'b111, {2'd2, 2'd1, 2'd0}, 3};
    vt[2] = '{3'b001, {2'd0, 2'd0, 2'd0}, 1};
    vt[3] = '{3'b101, {2'd0, 2'd0, 2'd2}, 2};
    vt[4] = '{3'b110, {2'd0, 2'd2, 2'd1}, 2};
    vt[5] = '{3'b011, {2'd0, 2'd1, 2'd0}, 2};
    vt[6] = '{3'b100, {2'd0, 2'd0, 2'd2}, 1};
    vt[7] = '{3'b010, {2'd0, 2'd0, 2'd1}, 1};

    // reset state
    repeat (3) @(negedge CLK);
    check("rst_send", bus.send, 0);
    check("rst_send_data", bus.send_data, 0);
    check("rst_req_ack", bus.req_ack, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // round-robin among simultaneous single-byte messages
    for (int v = 0; v < 8; v++) begin
      @(posedge CLK);
      #1;
      for (int i = 0; i < N; i++)
        if (vt[v].mask[i]) enq(i, 8'((v + 1) * 16 + i), 1'b1);
      for (int k = 0; k < vt[v].n; k++)
        push(int'(vt[v].ord[2*k +: 2]), 8'((v + 1) * 16 + int'(vt[v].ord[2*k +: 2])));
      wait_drain("vec_drain", 400);
    end

    // single requester, 3-byte message, long character time
    char_cyc = 100;
    base_s = n_send;
    base_a = n_ack;
    @(posedge CLK);
    #1;
    enq(0, 8'h41, 1'b0);
    enq(0, 8'h52, 1'b0);
    enq(0, 8'h0D, 1'b1);
    push(0, 8'h41);
    push(0, 8'h52);
    push(0, 8'h0D);
    bad  = 0;
    done = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge CLK);
      if (bus.busy && bus.grant != 3'b001) bad++;
      if (c > 2 && sbq.size() == 0 && !bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    check("msg3_done", done, 1'b1);
    check("msg3_grant_held", bad, 0);
    check("msg3_sends", n_send - base_s, 3);
    check("msg3_acks", n_ack - base_a, 3);
    check("msg3_grant_idle", bus.grant, 0);
    char_cyc = 20;

    // requester 1 arrives mid-message of requester 0
    base_s = n_send;
    @(posedge CLK);
    #1;
    enq(0, 8'hC1, 1'b0);
    enq(0, 8'hC2, 1'b1);
    push(0, 8'hC1);
    push(0, 8'hC2);
    push(1, 8'hD1);
    wait_sends("hold_first_send", base_s + 1, 100);
    enq(1, 8'hD1, 1'b1);
    wait_sends("hold_second_send", base_s + 2, 200);
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
    end
    check("hold_idle_seen", done, 1'b1);
    @(negedge CLK);
    check("hold_r1_grant", bus.grant, 3'b010);
    check("hold_r1_send", bus.send, 1'b1);
    wait_drain("hold_drain", 200);

    // ready low in IDLE blocks the load
    hold_rdy = 1'b1;
    @(posedge CLK);
    #1;
    base_s = n_send;
    base_a = n_ack;
    enq(0, 8'hE1, 1'b1);
    push(0, 8'hE1);
    repeat (20) @(negedge CLK);
    check("rdy_low_no_send", n_send - base_s, 0);
    check("rdy_low_no_ack", n_ack - base_a, 0);
    hold_rdy = 1'b0;
    @(negedge CLK);
    check("rdy_rise_send", bus.send, 1'b1);
    wait_drain("rdy_drain", 200);

    // reset in WAIT_RDY mid-message
    base_s = n_send;
    @(posedge CLK);
    #1;
    enq(2, 8'hF1, 1'b0);
    enq(2, 8'hF2, 1'b1);
    push(2, 8'hF1);
    wait_sends("rst_mid_send", base_s + 1, 100);
    repeat (3) @(negedge CLK);
    enq(0, 8'hF3, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check("rst_async_grant", bus.grant, 0);
    check("rst_async_send", bus.send, 0);
    check("rst_async_ack", bus.req_ack, 0);
    check("rst_async_busy", bus.busy, 0);
    repeat (2) @(negedge CLK);
    push(0, 8'hF3);
    push(2, 8'hF2);
    RST = 1'b0;
    wait_drain("rst_drain", 300);

    // owner stalls mid-message
    base_s = n_send;
    @(posedge CLK);
    #1;
    enq(1, 8'h61, 1'b0);
    enq(2, 8'h62, 1'b1);
    push(1, 8'h61);
    wait_sends("stall_send", base_s + 1, 100);
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      #1;
      if (bus.ready) begin
        done = 1'b1;
        break;
      end
    end
    check("stall_ready_back", done, 1'b1);
`ifdef UART_ARB_TIMEOUT_EN
    push(2, 8'h62);
    pulses = 0;
    at_c   = -1;
    g_at   = '1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      #1;
      if (bus.timeout_err) begin
        pulses++;
        if (at_c < 0) begin
          at_c = c;
          g_at = bus.grant;
        end
      end
    end
    check("tmo_pulses", pulses, 1);
    check("tmo_cycle", at_c, 17);
    check("tmo_grant_dropped", g_at, 0);
    wait_drain("tmo_drain", 200);
`else
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (bus.timeout_err) pulses++;
    end
    check("stall_grant_held", bus.grant, 3'b010);
    check("stall_no_timeout", pulses, 0);
    enq(1, 8'h63, 1'b1);
    push(1, 8'h63);
    push(2, 8'h62);
    wait_drain("stall_drain", 300);
`endif

    check("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_TX_CTRL transmitter between NUM_REQ independent message sources, such as the button banner string, the RX echo path and status reporters.
- Grants are message-granular and round-robin: once a requester wins, it keeps the transmitter until its byte marked last has been sent.
- Drives the transmitter's send/send_data/ready handshake, including the one-cycle settle gap the transmitter requires after send.
- Sits between the application-level message generators and UART_TX_CTRL in the top level.

Parameters:
- NUM_REQ, 3: number of requesters, 2..8.
- TIMEOUT_CYC, 1024: idle cycles allowed mid-message before the grant is revoked (used only with UART_ARB_TIMEOUT_EN).

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous reset, active-high.
- req_valid  input  NUM_REQ  requester i presents a byte.
- req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- req_last  input  NUM_REQ  the presented byte ends requester i's message.
- req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i consumed.
- send  output  1  one-cycle start pulse to UART_TX_CTRL.
- send_data  output  8  byte to UART_TX_CTRL; held stable until the next load.
- ready  input  1  UART_TX_CTRL idle and able to accept a byte.
- grant  output  NUM_REQ  one-hot owner of the transmitter; 0 when idle.
- busy  output  1  high whenever state is not IDLE.
- timeout_err  output  1  one-cycle pulse (only with UART_ARB_TIMEOUT_EN, otherwise tied 0).

Behaviour:
- All outputs are registered.
- On RST:
  - state=IDLE.
  - send=0, send_data=0, req_ack=0, grant=0, busy=0, timeout_err=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-message aborts the grant immediately. No byte is replayed; the transmitter finishes any byte already in flight on its own, and IDLE waits for ready before the next load.
- States: IDLE, SETTLE, WAIT_RDY, NEXT.
- IDLE:
  - If ready=1 and any req_valid=1, the winner is the first valid requester searching upward (modulo NUM_REQ) from pointer+1.
  - LOAD action on that edge: grant<=onehot(winner); send<=1; send_data<=winner's byte; req_ack[winner]<=1; last_flag<=req_last[winner]; state<=SETTLE.
  - If ready=0, no grant is issued.
- SETTLE: send<=0, req_ack<=0; go to WAIT_RDY unconditionally. This absorbs the transmitter's ready-deassert latency.
- WAIT_RDY: hold until ready=1.
  - If last_flag=1: grant<=0, pointer<=current owner, state<=IDLE.
  - If last_flag=0: state<=NEXT.
- NEXT: when req_valid[owner]=1, perform LOAD for the owner only (no re-arbitration), then go to SETTLE. Other requesters are ignored until the message completes.
- Latency and throughput:
  - req_valid seen in IDLE with ready=1: send is high in the next cycle, together with req_ack.
  - Minimum spacing between send pulses is the UART character time plus 2 cycles.
- Requester contract:
  - Hold valid, data and last stable until req_ack is seen.
  - Update or drop them in the cycle after req_ack.
  - A requester dropping valid before it is granted is legal; no ack is issued.
- Single-byte messages (req_last=1 on the first byte) are legal and return to IDLE after one byte.
- Simultaneous requests in IDLE are resolved by round-robin only. A lone requester may win repeatedly.
- send never asserts while ready=0 at the load decision. send_data changes only on a LOAD.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on every LOAD and increments each cycle spent in NEXT with req_valid[owner]=0.
  - On reaching TIMEOUT_CYC: timeout_err pulses for 1 cycle, grant<=0, pointer<=owner, state<=IDLE.
  - The counter is held at 0 in all other states.
- Disabled: no counter is built, timeout_err is driven constant 0, and NEXT waits indefinitely.

Test Plan:
- Single requester, 3-byte message 0x41,0x52,0x0D (last on 0x0D), ready model deasserting 1 cycle after send for 100 cycles -> exactly 3 send pulses with matching send_data, 3 req_ack pulses, grant=001 throughout, back to IDLE with busy=0.
- req_valid=111 simultaneously after reset, each with a 1-byte message -> service order 0,1,2. Repeat req_valid=111 -> order 0,1,2 again. Verify pointer behaviour with req_valid=101 after owner 0 -> requester 2 wins.
- Requester 0 sends a 2-byte message while requester 1 asserts valid at the first ack -> both of requester 0's bytes are sent before any requester-1 byte. Requester 1 is granted in the cycle after IDLE is re-entered with ready=1.
- Hold ready=0 in IDLE with req_valid=001 for 20 cycles -> no send and no ack. Raise ready -> send in the next cycle.
- Assert RST in WAIT_RDY mid-message -> grant, send, req_ack and busy all 0 asynchronously. After release, the first byte goes to requester 0 if it is valid.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, the owner drops valid after its first non-last byte -> timeout_err pulses once 16 cycles after entering NEXT, grant=0, and the next requester is served. Without the macro, grant is still held after 100 cycles.
